// File: rtl/stpu_timer.sv
// Programmable interval timer slave for the stpu data bus.
// One-shot/periodic count-down with 8-bit prescaler and W1C pending flag.
module stpu_timer #(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] RST_LOAD = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    logic             en, periodic, ie, pend;
    logic [7:0]       presc, pcnt;
    logic [CNT_W-1:0] load, count, load_new;
    logic [31:0]      load_ext, count_ext, load_merged, rdata;
    logic             wr, rd, wr_ctrl, wr_load, wr_stat;
    logic             tick, event_t;
    logic             unused_ok;

    assign wr      = ce_i & we_i;
    assign rd      = ce_i & ~we_i;
    assign wr_ctrl = wr & (addr_i[3:2] == 2'd0);
    assign wr_load = wr & (addr_i[3:2] == 2'd1) & (|sel_i);
    assign wr_stat = wr & (addr_i[3:2] == 2'd3) & sel_i[0] & data_i[0];

    assign tick    = en & (pcnt == presc);
    assign event_t = tick & (count == '0);

    always_comb begin
        load_ext = '0;
        load_ext[CNT_W-1:0] = load;
        count_ext = '0;
        count_ext[CNT_W-1:0] = count;
        for (int b = 0; b < 4; b++) begin
            load_merged[8*b +: 8] = sel_i[b] ? data_i[8*b +: 8]
                                             : load_ext[8*b +: 8];
        end
    end

    assign load_new  = load_merged[CNT_W-1:0];
    assign unused_ok = ^{addr_i[1:0], load_merged};

    always_comb begin
        rdata = '0;
        unique case (addr_i[3:2])
            2'd0: rdata = {16'b0, presc, 5'b0, ie, periodic, en};
            2'd1: rdata = load_ext;
            2'd2: rdata = count_ext;
            2'd3: rdata = {31'b0, pend};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            ie       <= 1'b0;
            presc    <= '0;
            pcnt     <= '0;
            load     <= RST_LOAD;
            count    <= '0;
            pend     <= 1'b0;
            data_o   <= '0;
        end else begin
            if (rd) data_o <= rdata;

            if (wr_load || !en || tick) pcnt <= '0;
            else                        pcnt <= pcnt + 8'd1;

            if (wr_load) begin
                count <= load_new;
                load  <= load_new;
            end else if (tick) begin
                if (count != '0) count <= count - CNT_W'(1);
                else if (periodic) count <= load;
            end

            // A same-cycle CTRL write overrides the one-shot EN clear.
            if (event_t && !periodic) en <= 1'b0;
            if (wr_ctrl && sel_i[0]) begin
                en       <= data_i[0];
                periodic <= data_i[1];
                ie       <= data_i[2];
            end
            if (wr_ctrl && sel_i[1]) presc <= data_i[15:8];

            if (wr_stat) pend <= 1'b0;
            if (event_t) pend <= 1'b1;
        end
    end

    assign irq_o = pend & ie;

endmodule

// File: tb/tb_stpu_timer.sv
// Self-checking bench for stpu_timer: directed scenarios plus
// randomized bus traffic against a cycle-level reference model.
module tb_stpu_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // reference state, kept as plain spec-level quantities
    bit       m_en, m_per, m_ie, m_pend;
    int       m_presc, m_phase;
    bit [31:0] m_load, m_count, m_data;

    stpu_timer dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i),
        .addr_i(addr_i), .sel_i(sel_i), .data_i(data_i),
        .data_o(data_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_reg(input int idx);
        case (idx)
            0: return {16'b0, 8'(m_presc), 5'b0, m_ie, m_per, m_en};
            1: return m_load;
            2: return m_count;
            default: return {31'b0, m_pend};
        endcase
    endfunction

    function automatic void model_step(input bit c, w, input bit [3:0] a,
                                       s, input bit [31:0] d, input bit r);
        bit tick, fire, en_n, pend_n;
        bit [31:0] cnt_n, nl;
        int ph_n;
        if (r) begin
            m_en = 0; m_per = 0; m_ie = 0; m_pend = 0;
            m_presc = 0; m_phase = 0;
            m_load = 0; m_count = 0; m_data = 0;
            return;
        end
        if (c && !w) m_data = m_reg(int'(a[3:2]));
        // a tick is the (presc+1)-th enabled cycle of a prescale phase
        tick = m_en && (m_phase == m_presc);
        fire = tick && (m_count == 0);
        ph_n = (!m_en || tick) ? 0 : m_phase + 1;
        cnt_n = m_count;
        if (tick) cnt_n = (m_count > 0) ? m_count - 1
                        : (m_per ? m_load : 0);
        en_n = (fire && !m_per) ? 1'b0 : m_en;
        pend_n = m_pend;
        if (c && w && a[3:2] == 3 && s[0] && d[0]) pend_n = 0;
        if (fire) pend_n = 1;
        if (c && w && a[3:2] == 0) begin
            if (s[0]) begin en_n = d[0]; m_per = d[1]; m_ie = d[2]; end
            if (s[1]) m_presc = int'(d[15:8]);
        end
        if (c && w && a[3:2] == 1 && s != 0) begin
            nl = m_load;
            for (int b = 0; b < 4; b++)
                if (s[b]) nl[8*b +: 8] = d[8*b +: 8];
            m_load = nl; cnt_n = nl; ph_n = 0;
        end
        m_en = en_n; m_pend = pend_n; m_count = cnt_n; m_phase = ph_n;
    endfunction

    task automatic bus(input bit c, w, input bit [3:0] a, s,
                       input bit [31:0] d, input bit r);
        ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d; rst = r;
        @(posedge clk);
        model_step(c, w, a, s, d, r);
        #1;
        cyc++;
        chk("model_data_o", data_o, m_data);
        chk("model_irq_o", {31'b0, irq_o}, {31'b0, m_pend & m_ie});
        ce_i = 0; we_i = 0; rst = 0;
    endtask

    task automatic wr(input bit [3:0] a, input bit [31:0] d,
                      input bit [3:0] s = 4'hF);
        bus(1, 1, a, s, d, 0);
    endtask

    task automatic rd(input bit [3:0] a);
        bus(1, 0, a, 4'h0, 32'h0, 0);
    endtask

    task automatic idle();
        bus(0, 0, 4'h0, 4'h0, 32'h0, 0);
    endtask

    initial begin
        int t0, t1, c0;
        bit [3:0] ra, rs;
        bit [31:0] rdv;
        bit rc, rw, rr;

        bus(0, 0, 0, 0, 0, 1);
        chk("rst_irq", {31'b0, irq_o}, 0);
        chk("rst_data", data_o, 0);
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4));
            chk("rst_reg", data_o, 0);
        end

        // one-shot
        wr(4'h4, 3);
        wr(4'h0, 32'h5);
        for (int i = 0; i < 4; i++) begin
            rd(4'h8);
            chk("os_count", data_o, 32'(3 - i));
            chk("os_irq", {31'b0, irq_o}, (i == 3) ? 1 : 0);
        end
        rd(4'h0);
        chk("os_ctrl_en_clr", data_o, 32'h4);
        rd(4'h8);
        chk("os_count_hold", data_o, 0);
        wr(4'hC, 1);
        chk("os_w1c_irq", {31'b0, irq_o}, 0);

        // periodic with prescale 2
        wr(4'h4, 1);
        wr(4'h0, 32'h0207);
        for (int i = 0; i < 20 && !irq_o; i++) idle();
        chk("per_seen0", {31'b0, irq_o}, 1);
        t0 = cyc;
        rd(4'hC);
        chk("per_pend_held", data_o, 1);
        wr(4'hC, 1);
        chk("per_cleared", {31'b0, irq_o}, 0);
        for (int i = 0; i < 20 && !irq_o; i++) idle();
        chk("per_seen1", {31'b0, irq_o}, 1);
        t1 = cyc;
        chk("per_period", 32'(t1 - t0), (1 + 1) * (2 + 1));

        // W1C landing on the next terminal event
        c0 = t1;
        wr(4'hC, 1);
        while (cyc < c0 + 5) idle();
        wr(4'hC, 1);
        chk("w1c_collide", {31'b0, irq_o}, 1);
        wr(4'hC, 1);
        chk("w1c_after", {31'b0, irq_o}, 0);
        rd(4'hC);
        chk("w1c_status", data_o, 0);
        wr(4'h0, 0);

        // byte enables
        wr(4'h4, 0);
        wr(4'h4, 32'hAABBCCDD, 4'b0101);
        rd(4'h4);
        chk("be_load", data_o, 32'h00BB00DD);
        rd(4'h8);
        chk("be_count", data_o, 32'h00BB00DD);
        wr(4'h8, 32'h12345678);
        rd(4'h8);
        chk("count_ro", data_o, 32'h00BB00DD);

        // reset mid-count
        wr(4'h4, 100);
        wr(4'h0, 32'h3);
        for (int i = 0; i < 59; i++) idle();
        rd(4'h8);
        chk("mid_count", data_o, 41);
        bus(1, 1, 4'h4, 4'hF, 32'h55, 1);
        chk("mid_rst_irq", {31'b0, irq_o}, 0);
        chk("mid_rst_data", data_o, 0);
        for (int i = 0; i < 10; i++) idle();
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4));
            chk("mid_rst_reg", data_o, 0);
        end

        // read latency and IE mask
        wr(4'h0, 32'h5);
        idle();
        rd(4'hC);
        chk("ie_pend", data_o, 1);
        chk("ie_irq_on", {31'b0, irq_o}, 1);
        rd(4'h0);
        chk("lat_ctrl", data_o, 32'h4);
        idle();
        chk("lat_hold", data_o, 32'h4);
        wr(4'h0, 32'h0);
        chk("ie_masked", {31'b0, irq_o}, 0);
        rd(4'hC);
        chk("ie_pend_kept", data_o, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 199) == 0);
            rc = 1'($urandom_range(0, 3) != 0);
            rw = 1'($urandom);
            ra = 4'($urandom);
            rs = 4'($urandom);
            rdv = $urandom;
            if (ra[3:2] == 0) rdv[15:8] = {6'b0, rdv[9:8]};
            if (ra[3:2] == 1 && $urandom_range(0, 3) != 0) rdv &= 32'h7;
            bus(rc, rw, ra, rs, rdv, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stpu_timer.md
Name: stpu_timer

Overview:
- Memory-mapped programmable interval timer that feeds the CPU external interrupt vector.
- Its `irq_o` drives `int_i[1]` of the stpu core; `int_i[0]` stays with the core-internal timer.
- Sits on the CPU data bus as a slave: 32-bit registers, byte-select writes, registered reads.
- Provides one-shot and periodic modes, an 8-bit prescaler, and a write-1-to-clear pending flag.

Parameters:
- CNT_W, 32, width of the LOAD and COUNT registers (legal range 8..32).
- RST_LOAD, 0, reset value of LOAD.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ce_i  input  1  bus access strobe; one access per cycle it is high.
- we_i  input  1  1 = write, 0 = read; ignored when ce_i=0.
- addr_i  input  4  byte address; [3:2] selects the register, [1:0] ignored.
- sel_i  input  4  byte enables for writes; sel_i[n] enables byte n.
- data_i  input  32  write data.
- data_o  output  32  read data, valid the cycle after a read access.
- irq_o  output  1  level interrupt request, active high.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Register map:
  - 0x0 CTRL (RW): [0] EN, [1] PERIODIC, [2] IE, [15:8] PRESC; other bits read 0.
  - 0x4 LOAD (RW): [CNT_W-1:0]; upper bits read 0.
  - 0x8 COUNT (RO): current count; writes ignored.
  - 0xC STATUS: [0] PEND, write-1-to-clear; other bits read 0.
- Reset (rst=1 at a clock edge) sets:
  - CTRL=0, LOAD=RST_LOAD, COUNT=0, PEND=0, prescale counter=0, data_o=0.
  - irq_o is therefore 0. Reset dominates any same-cycle access.
- Writes: apply per byte under sel_i and take effect at the clock edge.
  - A write to LOAD (any byte) also loads COUNT with the new LOAD value and clears the prescale counter.
  - A LOAD write overrides the count update in the same cycle.
- Reads: data_o is registered with 1-cycle latency.
  - data_o holds its last value on cycles without a read.
  - A read returns register contents before any same-cycle update.
- Tick generation:
  - While EN=1, the prescale counter increments each cycle.
  - When it equals PRESC, a tick occurs and the counter returns to 0. PRESC=0 gives a tick every cycle.
  - While EN=0, the prescale counter is held at 0.
- On each tick:
  - If COUNT≠0, COUNT decrements by 1.
  - If COUNT=0, it is a terminal event: PEND is set. If PERIODIC=1, COUNT reloads from LOAD. If PERIODIC=0, COUNT stays 0 and EN clears.
- Period: the event period is (LOAD+1)*(PRESC+1) cycles. LOAD=0 with PERIODIC=1 fires on every tick.
- Same-cycle CTRL write and tick: the tick is evaluated with the old CTRL; the new CTRL applies from the next cycle.
- Terminal event clearing EN while CTRL is written in the same cycle: the written EN value wins.
- Same-cycle PEND set (event) and W1C clear: set wins, so PEND=1.
- irq_o = PEND & IE. It is driven purely from registers, with no combinational path from bus inputs.
  - Clearing IE masks irq_o but leaves PEND set.
- COUNT wraps never: decrement stops at 0. No underflow past 0.

Test Plan:
- One-shot: write LOAD=3, then CTRL=0x5 (EN, IE, PRESC=0).
  - Required: COUNT reads 3,2,1,0; PEND and irq_o rise 4 cycles after EN is seen; EN reads 0 afterwards; COUNT stays 0.
- Periodic with prescale: LOAD=1, CTRL=0x0207 (PRESC=2).
  - Required: events every 6 cycles; PEND stays 1 until W1C; irq_o follows.
- W1C collision: clear PEND via a write of 0x1 to 0xC in the exact cycle of a terminal event.
  - Required: PEND remains 1; a clear on the next cycle gives PEND=0 and irq_o=0.
- Byte-enable write: LOAD=0, then write 0xAABBCCDD to LOAD with sel=0b0101.
  - Required: LOAD and COUNT read 0x00BB00DD; a write to COUNT is ignored.
- Reset mid-count: LOAD=100, periodic, assert rst at COUNT=40.
  - Required: next cycle all registers are 0, irq_o=0, and data_o=0; the counter stays idle after rst drops.
- Read latency and IE mask:
  - Read CTRL at cycle N; required: data_o is valid at N+1.
  - With PEND=1, clear IE; required: irq_o=0 and STATUS still reads 1.
